// File: rtl/norm_shift.sv
// Iterative normalizer: shifts an operand one bit per clock until its MSB (d=0)
// or LSB (d=1) is set, reporting the shifted value and the number of positions moved.
module norm_shift #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic             d,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x,
   output logic [CNT_W-1:0] n,
   output logic             zero
);

   // state  | meaning
   // S_IDLE | waiting for start
   // S_RUN  | shifting work one bit per cycle until the target bit is set
   // S_DONE | one-cycle result strobe; start here is accepted back-to-back
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic             zero_q, zero_d;
   logic             hit;

   assign hit = dir_q ? work_q[0] : work_q[WIDTH-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         x_q     <= '0;
         n_q     <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         n_q     <= n_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      n_d     = n_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               work_d  = a;
               dir_d   = d;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (work_q == '0) begin
               state_d = S_DONE;
               x_d     = '0;
               n_d     = '0;
               zero_d  = 1'b1;
            end else if (hit) begin
               state_d = S_DONE;
               x_d     = work_q;
               n_d     = cnt_q;
               zero_d  = 1'b0;
            end else begin
               work_d = dir_q ? (work_q >> 1) : (work_q << 1);
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               work_d  = a;
               dir_d   = d;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign x    = x_q;
   assign n    = n_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_norm_shift.sv
// Self-checking bench for norm_shift: directed corner cases plus randomized
// operands against a bit-scan reference model, including latency.
module tb_norm_shift;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic       d;
   logic       busy;
   logic       done;
   logic [7:0] x;
   logic [2:0] n;
   logic       zero;

   int checks = 0;
   int errors = 0;

   norm_shift #(.WIDTH(8), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .d     (d),
      .busy  (busy),
      .done  (done),
      .x     (x),
      .n     (n),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Leading-zero (d=0) or trailing-zero (d=1) count from a plain bit scan.
   function automatic void model(input logic [7:0] av, input logic dv,
                                 output logic [7:0] xe, output int ne, output logic ze);
      bit found;
      ze    = (av == 8'h00);
      ne    = 0;
      xe    = 8'h00;
      found = 0;
      if (!ze) begin
         for (int i = 0; i < 8; i++) begin
            if (!found && av[dv ? i : 7 - i]) begin
               ne    = i;
               found = 1;
            end
         end
         xe = dv ? (av >> ne) : (av << ne);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for done after the accepting edge; returns edges counted after it.
   task automatic wait_done(input string tag, output int lat);
      lat = 0;
      while (lat < 20) begin
         tick();
         lat++;
         if (done) break;
      end
      if (!done) chk({tag, "_timeout"}, 32'(lat), 32'(0));
   endtask

   task automatic check_result(input string tag, input logic [7:0] av, input logic dv, input int lat);
      logic [7:0] xe;
      int         ne;
      logic       ze;
      model(av, dv, xe, ne, ze);
      chk({tag, "_x"}, 32'(x), 32'(xe));
      chk({tag, "_n"}, 32'(n), 32'(ne));
      chk({tag, "_zero"}, 32'(zero), 32'(ze));
      chk({tag, "_lat"}, 32'(lat), 32'(ne + 1));
      if (!ze) begin
         chk({tag, "_tbit"}, 32'(dv ? x[0] : x[7]), 32'(1));
         chk({tag, "_inv"}, 32'(dv ? (x << n) : (x >> n)), 32'(av));
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] av, input logic dv);
      int lat;
      a     = av;
      d     = dv;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = $urandom_range(255);
      d     = $urandom_range(1);
      wait_done(tag, lat);
      check_result(tag, av, dv, lat);
      chk({tag, "_busy_in_done"}, 32'(busy), 32'(0));
      tick();
      chk({tag, "_done_pulse"}, 32'(done), 32'(0));
   endtask

   initial begin
      int         lat;
      bit         seen;
      logic [7:0] xh;
      logic [2:0] nh;
      rst_n = 1'b0;
      start = 1'b0;
      a     = 8'h00;
      d     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_x", 32'(x), 32'(0));
      chk("rst_n", 32'(n), 32'(0));
      chk("rst_zero", 32'(zero), 32'(0));

      run_op("l01", 8'h01, 1'b0);
      run_op("l80", 8'h80, 1'b0);
      run_op("r30", 8'h30, 1'b1);
      run_op("r80", 8'h80, 1'b1);
      run_op("z0", 8'h00, 1'b0);
      run_op("z1", 8'h00, 1'b1);

      // Results hold between done pulses.
      xh = x;
      nh = n;
      repeat (4) tick();
      chk("hold_x", 32'(x), 32'(xh));
      chk("hold_n", 32'(n), 32'(nh));

      // Start held high with a/d changed mid-run, then back-to-back accept in DONE.
      a     = 8'h10;
      d     = 1'b0;
      start = 1'b1;
      tick();
      chk("b2b_busy", 32'(busy), 32'(1));
      a = 8'h55;
      d = 1'b1;
      wait_done("b2b_first", lat);
      check_result("b2b_first", 8'h10, 1'b0, lat);
      a = 8'h30;
      d = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_rebusy", 32'(busy), 32'(1));
      chk("b2b_nodone", 32'(done), 32'(0));
      wait_done("b2b_second", lat);
      check_result("b2b_second", 8'h30, 1'b1, lat);
      tick();

      // Reset mid-operation discards the result.
      a     = 8'h01;
      d     = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_busy", 32'(busy), 32'(0));
      chk("mrst_done", 32'(done), 32'(0));
      chk("mrst_x", 32'(x), 32'(0));
      chk("mrst_n", 32'(n), 32'(0));
      chk("mrst_zero", 32'(zero), 32'(0));
      seen = 0;
      repeat (12) begin
         tick();
         if (done || busy) seen = 1;
      end
      chk("mrst_no_done", 32'(seen), 32'(0));
      run_op("post_rst", 8'h04, 1'b0);

      for (int i = 0; i < 500; i++) begin
         logic [7:0] rv;
         rv = 8'($urandom_range(255));
         if (i % 50 == 0) rv = 8'h00;
         run_op("rnd_l", rv, 1'b0);
         run_op("rnd_r", rv, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/norm_shift.md
Name: norm_shift

Overview:
- Iterative normalizer: the inverse of the combinational left/right shifter.
- Takes an operand and a direction, then shifts one bit per clock until the operand is normalized.
- Returns the normalized value and the shift count, such that shifting x by n in the opposite direction (~d) reproduces a exactly.
- Sits beside the shifter in the datapath. It feeds the shifter's d/n inputs for denormalization and serves leading/trailing-zero counting.

Parameters:
- WIDTH, 8, operand width in bits.
- CNT_W, 3, shift-count width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- start  input  1  request; accepted only when busy==0.
- a  input  WIDTH  operand; sampled on the accepting edge.
- d  input  1  0 = normalize left (MSB to bit WIDTH-1, leading-zero count); 1 = normalize right (LSB to bit 0, trailing-zero count); sampled with a.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- x  output  WIDTH  normalized operand.
- n  output  CNT_W  number of bit positions shifted.
- zero  output  1  operand was all-zero.

Behaviour:
- Reset (rst_n==0 at a clk edge): state=IDLE, busy=0, done=0, x=0, n=0, zero=0, internal work/count registers=0. Reset wins over every other input, including mid-operation; the in-flight result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start==1 → load work=a, dir=d, cnt=0; go RUN.
  - Otherwise stay.
- RUN, evaluated every cycle:
  - work==0 → go DONE with zero flag set, count 0.
  - dir==0 and work[WIDTH-1]==1, or dir==1 and work[0]==1 → go DONE.
  - Otherwise work shifts by 1 (left if dir==0, right if dir==1, zero fill), cnt+=1, stay RUN.
  - cnt never exceeds WIDTH-1, because a nonzero operand hits the target bit within WIDTH-1 shifts.
- DONE (one cycle):
  - done=1; x, n, zero update on the edge entering DONE.
  - start==1 in this cycle is accepted (back-to-back): load a/d and go RUN.
  - Otherwise go IDLE.
- busy=1 in RUN only; busy=0 in IDLE and DONE.
- start while busy==1 is ignored and not queued; a/d changes while busy do not affect the operation.
- Latency: start sampled at edge k → done high in the cycle after edge k+n+1. That is n+1 RUN cycles, with done visible at edge k+n+2.
  - All-zero operand: n=0, done at edge k+2.
- x, n, zero hold their values between done pulses, until the next done edge.
- Zero operand: x=0, n=0, zero=1. Nonzero operand: zero=0.
- Invariant for nonzero a:
  - dir==0: x[WIDTH-1]==1 and (x >> n)==a.
  - dir==1: x[0]==1 and (x << n)==a.

Test Plan:
- Reset, then idle 3 cycles → busy=0, done=0, x=0x00, n=0, zero=0; start=0 changes nothing.
- a=0x01, d=0, start pulse at edge k → busy for 8 cycles; done at edge k+9 with x=0x80, n=7, zero=0. Then a=0x80, d=0 → done at k'+2, x=0x80, n=0.
- a=0x30, d=1 → x=0x03, n=4, done at edge k+6. Also a=0x80, d=1 → x=0x01, n=7.
- a=0x00, either d → done at edge k+2, x=0x00, n=0, zero=1.
- Interference: start with a=0x55 asserted again while busy → ignored, first result is still delivered. Start held high through DONE → back-to-back operation accepted, busy reasserts the next cycle. Changing a/d mid-RUN → no effect.
- Reset mid-operation: a=0x01, d=0, rst_n=0 for 1 cycle at k+3 → all outputs 0, no done pulse, IDLE. A following a=0x04, d=0 → x=0x80, n=5.
- Randomized 500 operands × both d → check the invariant against a golden model of the combinational shifter, including the latency n+2.
